status_reg: RTL

//  6502 processor status register (P). Directly downstream of the ALU: captures
//  alu_Y/alu_carry_out/alu_overflow into N V Z C under control-unit enables.

---
 rtl/status_reg_pkg.sv | 35 +++
 rtl/status_reg_irq_mask_delay.sv | 70 +++++++
 rtl/status_reg.sv | 127 ++++++++++++
 3 files changed

// File: rtl/status_reg_pkg.sv
// Shared encodings for the 6502 status register and the control unit that drives it.
package status_reg_pkg;

   // Bit positions inside the P image
   localparam int P_C = 0;
   localparam int P_Z = 1;
   localparam int P_I = 2;
   localparam int P_D = 3;
   localparam int P_B = 4;
   localparam int P_5 = 5;
   localparam int P_V = 6;
   localparam int P_N = 7;

   // flag_op encodings
   localparam logic [2:0] FLAG_OP_NONE = 3'b000;
   localparam logic [2:0] FLAG_OP_SEC  = 3'b001;
   localparam logic [2:0] FLAG_OP_CLC  = 3'b010;
   localparam logic [2:0] FLAG_OP_SEI  = 3'b011;
   localparam logic [2:0] FLAG_OP_CLI  = 3'b100;
   localparam logic [2:0] FLAG_OP_SED  = 3'b101;
   localparam logic [2:0] FLAG_OP_CLD  = 3'b110;
   localparam logic [2:0] FLAG_OP_CLV  = 3'b111;

   // flag_src encodings (11 is reserved and behaves as ALU)
   localparam logic [1:0] FLAG_SRC_ALU  = 2'b00;
   localparam logic [1:0] FLAG_SRC_PULL = 2'b01;
   localparam logic [1:0] FLAG_SRC_BIT  = 2'b10;

   // IRQ mask delay FSM states
   typedef enum logic {
      IM_IDLE = 1'b0,
      IM_PEND = 1'b1
   } im_state_e;

endpackage

// File: rtl/status_reg_irq_mask_delay.sv
// Delays changes of the I flag, as seen by interrupt sampling, by a number of
// instruction boundaries. SEI masks immediately; unmasking waits.
module irq_mask_delay
   import status_reg_pkg::*;
#(
   parameter int I_DELAY = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_i_wr,        // I flag written this cycle (SEI, CLI, PULL)
   input  logic i_i_new,       // value being written to I
   input  logic i_i_cur,       // live I register
   input  logic i_sei,         // the write is an SEI (fast-path mask)
   input  logic i_instr_done,  // instruction boundary strobe
   output logic o_mask_eff
);

   localparam int CW = (I_DELAY < 2) ? 1 : $clog2(I_DELAY + 1);

   im_state_e       r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_mask;
   im_state_e       w_state_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_mask_nxt;

   // State register: FSM state, boundary counter and the effective mask
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IM_IDLE;
         r_cnt   <= '0;
         r_mask  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mask  <= w_mask_nxt;
      end
   end

   // Next state: a write (re)loads the counter and wins over a coincident boundary
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mask_nxt  = r_mask;
      if (i_i_wr) begin
         if (I_DELAY == 0) begin
            w_state_nxt = IM_IDLE;
            w_mask_nxt  = i_i_new;
         end else begin
            w_state_nxt = IM_PEND;
            w_cnt_nxt   = CW'(I_DELAY);
            if (i_sei) w_mask_nxt = 1'b1;
         end
      end else if (r_state == IM_PEND && i_instr_done) begin
         if (r_cnt <= CW'(1)) begin
            w_state_nxt = IM_IDLE;
            w_cnt_nxt   = '0;
            w_mask_nxt  = i_i_cur;
         end else begin
            w_cnt_nxt = r_cnt - CW'(1);
         end
      end
   end

   // Output: effective mask is a plain register value
   always_comb begin
      o_mask_eff = r_mask;
   end

endmodule

// File: rtl/status_reg.sv
// 6502 processor status register: flag capture from the ALU, set/clear ops,
// PLP/RTI pulls, the stack push image and a delayed IRQ mask.
module status_reg
   import status_reg_pkg::*;
#(
   parameter logic [7:0] P_RESET = 8'h34,
   parameter int         I_DELAY = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] alu_Y,
   input  logic       alu_carry_out,
   input  logic       alu_overflow,
   input  logic [7:0] data_in,
   input  logic [1:0] flag_src,
   input  logic       upd_nz,
   input  logic       upd_c,
   input  logic       upd_v,
   input  logic       upd_all,
   input  logic [2:0] flag_op,
   input  logic       brk_push,
   input  logic       instr_done,
   output logic [7:0] p_reg,
   output logic [7:0] p_push,
   output logic       carry_flag,
   output logic       decimal_flag,
   output logic       irq_mask_eff
);

   logic r_n, r_v, r_d, r_i, r_z, r_c;
   logic w_n_nxt, w_v_nxt, w_d_nxt, w_i_nxt, w_z_nxt, w_c_nxt;
   logic w_pull_src, w_bit_src;
   logic w_src_n, w_src_v, w_src_z;
   logic w_i_wr, w_sei;
   logic w_unused;

   // B and bit5 do not exist as storage; pulled copies are dropped
   assign w_unused = ^data_in[5:4];

   assign w_pull_src = (flag_src == FLAG_SRC_PULL);
   assign w_bit_src  = (flag_src == FLAG_SRC_BIT);

   // Per-source values for the partial-update path (reserved source acts as ALU)
   assign w_src_n = (w_pull_src || w_bit_src) ? data_in[P_N] : alu_Y[7];
   assign w_src_v = (w_pull_src || w_bit_src) ? data_in[P_V] : alu_overflow;
   assign w_src_z = w_pull_src ? data_in[P_Z] : (alu_Y == 8'h00);

   // Per-bit next value: pull beats flag_op beats the individual enables
   always_comb begin
      w_n_nxt = r_n;
      w_v_nxt = r_v;
      w_d_nxt = r_d;
      w_i_nxt = r_i;
      w_z_nxt = r_z;
      w_c_nxt = r_c;
      if (upd_all) begin
         w_n_nxt = data_in[P_N];
         w_v_nxt = data_in[P_V];
         w_d_nxt = data_in[P_D];
         w_i_nxt = data_in[P_I];
         w_z_nxt = data_in[P_Z];
         w_c_nxt = data_in[P_C];
      end else begin
         if (upd_nz) begin
            w_n_nxt = w_src_n;
            w_z_nxt = w_src_z;
         end
         if (upd_v) w_v_nxt = w_src_v;
         if (upd_c) w_c_nxt = alu_carry_out;
         case (flag_op)
            FLAG_OP_SEC: w_c_nxt = 1'b1;
            FLAG_OP_CLC: w_c_nxt = 1'b0;
            FLAG_OP_SEI: w_i_nxt = 1'b1;
            FLAG_OP_CLI: w_i_nxt = 1'b0;
            FLAG_OP_SED: w_d_nxt = 1'b1;
            FLAG_OP_CLD: w_d_nxt = 1'b0;
            FLAG_OP_CLV: w_v_nxt = 1'b0;
            default:     ;
         endcase
      end
   end

   // Flag registers; I always comes out of reset set
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_n <= P_RESET[P_N];
         r_v <= P_RESET[P_V];
         r_d <= P_RESET[P_D];
         r_i <= 1'b1;
         r_z <= P_RESET[P_Z];
         r_c <= P_RESET[P_C];
      end else begin
         r_n <= w_n_nxt;
         r_v <= w_v_nxt;
         r_d <= w_d_nxt;
         r_i <= w_i_nxt;
         r_z <= w_z_nxt;
         r_c <= w_c_nxt;
      end
   end

   // Only a winning SEI takes the immediate-mask path; a pull overrides flag_op
   assign w_sei  = !upd_all && (flag_op == FLAG_OP_SEI);
   assign w_i_wr = upd_all || (flag_op == FLAG_OP_SEI) || (flag_op == FLAG_OP_CLI);

   irq_mask_delay #(
      .I_DELAY (I_DELAY)
   ) u_irq_mask_delay (
      .i_clk        (clk),
      .i_rst_n      (resetn),
      .i_i_wr       (w_i_wr),
      .i_i_new      (w_i_nxt),
      .i_i_cur      (r_i),
      .i_sei        (w_sei),
      .i_instr_done (instr_done),
      .o_mask_eff   (irq_mask_eff)
   );

   // Output images straight from the registers
   always_comb begin
      p_reg        = {r_n, r_v, 1'b1, 1'b0,     r_d, r_i, r_z, r_c};
      p_push       = {r_n, r_v, 1'b1, brk_push, r_d, r_i, r_z, r_c};
      carry_flag   = r_c;
      decimal_flag = r_d;
   end

endmodule
